rx_iq_fifo: RTL and testbench



---
 rtl/rx_iq_fifo.sv | 106 ++++++++++
 tb/tb_rx_iq_fifo.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/rx_iq_fifo.sv
// Show-ahead RX I/Q sample FIFO between the decimation chain and the MCU bus.
// Define RX_IQ_DUAL_CHANNEL_EN to store and present the RX2 pair alongside RX1.
module rx_iq_fifo #(
  parameter int DEPTH_LOG2 = 5,
  parameter int DATA_W     = 24
) (
  input  logic                  clk_in,
  input  logic                  reset_n,
  input  logic [DATA_W-1:0]     in_I,
  input  logic [DATA_W-1:0]     in_Q,
  input  logic [DATA_W-1:0]     in2_I,
  input  logic [DATA_W-1:0]     in2_Q,
  input  logic                  in_valid,
  input  logic                  IQ_RX_READ_REQ,
  input  logic                  IQ_RX_READ_CLK,
  output logic [DATA_W-1:0]     RX1_I,
  output logic [DATA_W-1:0]     RX1_Q,
  output logic [DATA_W-1:0]     RX2_I,
  output logic [DATA_W-1:0]     RX2_Q,
  output logic                  in_empty,
  output logic [DEPTH_LOG2:0]   fill_level,
  output logic                  overrun,
  output logic                  underrun,
  input  logic                  flags_clear
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LVL = (DEPTH_LOG2+1)'(DEPTH);
`ifdef RX_IQ_DUAL_CHANNEL_EN
  localparam int ENTRY_W = 4*DATA_W;
`else
  localparam int ENTRY_W = 2*DATA_W;
`endif

  logic [ENTRY_W-1:0]    mem [DEPTH];
  logic [ENTRY_W-1:0]    din, head;
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   ram_cnt;
  logic                  head_vld, read_clk_d;
  logic                  pop_ev, pop_ok, push_ok, full, ram_has, fetch, fwd;

`ifdef RX_IQ_DUAL_CHANNEL_EN
  assign din = {in2_Q, in2_I, in_Q, in_I};
`else
  assign din = {in_Q, in_I};
  logic unused_in2;
  assign unused_in2 = ^{in2_I, in2_Q};
`endif

  assign pop_ev  = IQ_RX_READ_CLK & ~read_clk_d & IQ_RX_READ_REQ;
  assign pop_ok  = pop_ev & head_vld;
  assign full    = (fill_level == FULL_LVL);
  assign push_ok = in_valid & (~full | pop_ok);
  // Entries still in RAM; the head has already been lifted into its register.
  assign ram_cnt = fill_level - {{DEPTH_LOG2{1'b0}}, head_vld};
  assign ram_has = (ram_cnt != '0);
  // Popping the last set while a new one arrives: bypass the RAM so the head never bubbles.
  assign fwd     = pop_ok & push_ok & ~ram_has;
  assign fetch   = ((pop_ok | ~head_vld) & ram_has) | fwd;

  always_ff @(posedge clk_in) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n)   head <= '0;
    else if (fetch) head <= fwd ? din : mem[rd_ptr];
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= '0;
      head_vld   <= 1'b0;
      read_clk_d <= 1'b0;
      overrun    <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      read_clk_d <= IQ_RX_READ_CLK;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (fetch)   rd_ptr <= rd_ptr + 1'b1;
      head_vld <= fetch | (head_vld & ~pop_ok);
      case ({push_ok, pop_ok})
        2'b10:   fill_level <= fill_level + 1'b1;
        2'b01:   fill_level <= fill_level - 1'b1;
        default: fill_level <= fill_level;
      endcase
      // A new event on the clearing edge keeps the flag set.
      overrun  <= (in_valid & full & ~pop_ok) | (overrun & ~flags_clear);
      underrun <= (pop_ev & ~head_vld) | (underrun & ~flags_clear);
    end
  end

  assign RX1_I    = head[DATA_W-1:0];
  assign RX1_Q    = head[2*DATA_W-1:DATA_W];
  assign in_empty = ~head_vld;
`ifdef RX_IQ_DUAL_CHANNEL_EN
  assign RX2_I = head[3*DATA_W-1:2*DATA_W];
  assign RX2_Q = head[4*DATA_W-1:3*DATA_W];
`else
  assign RX2_I = '0;
  assign RX2_Q = '0;
`endif

endmodule

// File: tb/tb_rx_iq_fifo.sv
// Bench for rx_iq_fifo: table-driven pushes, scoreboard-checked pops, and corner sequences.
module tb_rx_iq_fifo;
  localparam int DL = 5;
  localparam int DW = 24;
  localparam int DEPTH = 1 << DL;

  logic          clk_in = 0, reset_n = 0;
  logic [DW-1:0] in_I = 0, in_Q = 0, in2_I = 0, in2_Q = 0;
  logic          in_valid = 0, IQ_RX_READ_REQ = 1, IQ_RX_READ_CLK = 0, flags_clear = 0;
  logic [DW-1:0] RX1_I, RX1_Q, RX2_I, RX2_Q;
  logic          in_empty, overrun, underrun;
  logic [DL:0]   fill_level;

  rx_iq_fifo #(.DEPTH_LOG2(DL), .DATA_W(DW)) dut (
    .clk_in(clk_in), .reset_n(reset_n), .in_I(in_I), .in_Q(in_Q),
    .in2_I(in2_I), .in2_Q(in2_Q), .in_valid(in_valid),
    .IQ_RX_READ_REQ(IQ_RX_READ_REQ), .IQ_RX_READ_CLK(IQ_RX_READ_CLK),
    .RX1_I(RX1_I), .RX1_Q(RX1_Q), .RX2_I(RX2_I), .RX2_Q(RX2_Q),
    .in_empty(in_empty), .fill_level(fill_level), .overrun(overrun),
    .underrun(underrun), .flags_clear(flags_clear));

  always #5 clk_in = ~clk_in;

  typedef struct { logic [DW-1:0] i, q, i2, q2; } set_t;
  typedef struct { logic [DW-1:0] i, q; int exp_fill; } vec_t;

  set_t sb[$];
  vec_t tbl[5];
  int   n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk_in); #1;
  endtask

  function automatic set_t mk(input logic [DW-1:0] i, q, i2, q2);
    set_t s;
    s.i = i; s.q = q;
`ifdef RX_IQ_DUAL_CHANNEL_EN
    s.i2 = i2; s.q2 = q2;
`else
    s.i2 = '0; s.q2 = '0;
`endif
    return s;
  endfunction

  task automatic push(input logic [DW-1:0] i, q, i2, q2);
    in_I = i; in_Q = q; in2_I = i2; in2_Q = q2; in_valid = 1;
    if (sb.size() < DEPTH) sb.push_back(mk(i, q, i2, q2));
    tick();
    in_valid = 0;
  endtask

  task automatic chk_head(input string tag);
    set_t e;
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk({tag, "_I"},  32'(RX1_I), 32'(e.i));
    chk({tag, "_Q"},  32'(RX1_Q), 32'(e.q));
    chk({tag, "_I2"}, 32'(RX2_I), 32'(e.i2));
    chk({tag, "_Q2"}, 32'(RX2_Q), 32'(e.q2));
  endtask

  // Head is compared just before the rising strobe edge consumes it.
  task automatic pop(input int hold);
    chk_head("head");
    IQ_RX_READ_CLK = 1;
    repeat (hold) tick();
    IQ_RX_READ_CLK = 0;
    tick();
  endtask

  task automatic clear_flags();
    flags_clear = 1; tick(); flags_clear = 0;
  endtask

  initial begin
    tbl[0] = '{24'd1, 24'hFFFFF1, 4};
    tbl[1] = '{24'd2, 24'hFFFFF2, 3};
    tbl[2] = '{24'd3, 24'hFFFFF3, 2};
    tbl[3] = '{24'd4, 24'hFFFFF4, 1};
    tbl[4] = '{24'd5, 24'hFFFFF5, 0};

    #12;
    chk("rst_empty", 32'(in_empty), 1);
    chk("rst_fill", 32'(fill_level), 0);
    chk("rst_rx1i", 32'(RX1_I), 0);
    chk("rst_rx2i", 32'(RX2_I), 0);
    chk("rst_ovr", 32'(overrun), 0);
    chk("rst_unr", 32'(underrun), 0);
    reset_n = 1;
    tick();

    // Push latency into an empty FIFO
    push(24'h000123, 24'hFFFF00, 24'h0, 24'h0);
    chk("lat_fill_n", 32'(fill_level), 1);
    chk("lat_empty_n", 32'(in_empty), 1);
    tick();
    chk("lat_empty_n1", 32'(in_empty), 0);
    chk("lat_rx1i", 32'(RX1_I), 32'h000123);
    chk("lat_rx1q", 32'(RX1_Q), 32'hFFFF00);
    pop(1);
    chk("lat_drained", 32'(in_empty), 1);
    chk("lat_hold", 32'(RX1_I), 32'h000123);

    // Table: 5 sets, strobe held 3 cycles per pop
    foreach (tbl[k]) push(tbl[k].i, tbl[k].q, 24'h0, 24'h0);
    tick();
    chk("tbl_fill", 32'(fill_level), 5);
    foreach (tbl[k]) begin
      pop(3);
      chk("tbl_fill_after_pop", 32'(fill_level), 32'(tbl[k].exp_fill));
    end
    chk("tbl_empty", 32'(in_empty), 1);
    chk("tbl_hold", 32'(RX1_I), 5);
    chk("tbl_no_unr", 32'(underrun), 0);

    // Overfill by one, then drain
    for (int k = 0; k < DEPTH + 1; k++) push(24'h100 + DW'(k), 24'h0, 24'h0, 24'h0);
    chk("full_fill", 32'(fill_level), DEPTH);
    chk("full_ovr", 32'(overrun), 1);
    for (int k = 0; k < DEPTH; k++) pop(1);
    chk("full_last", 32'(RX1_I), 32'h100 + DEPTH - 1);
    chk("full_empty", 32'(in_empty), 1);
    chk("full_fill0", 32'(fill_level), 0);
    clear_flags();
    chk("ovr_clr", 32'(overrun), 0);

    // Empty pop and clear/event collision
    pop(1);
    chk("unr_set", 32'(underrun), 1);
    chk("unr_fill", 32'(fill_level), 0);
    flags_clear = 1; IQ_RX_READ_CLK = 1; tick();
    flags_clear = 0; IQ_RX_READ_CLK = 0; tick();
    chk("unr_event_wins", 32'(underrun), 1);
    clear_flags();
    chk("unr_clr", 32'(underrun), 0);

    // Full FIFO with push coincident with pop
    for (int k = 0; k < DEPTH; k++) push(24'h200 + DW'(k), 24'h0, 24'h0, 24'h0);
    tick();
    chk_head("fullpp");
    sb.push_back(mk(24'h2FF, 24'h0, 24'h0, 24'h0));
    in_I = 24'h2FF; in_valid = 1; IQ_RX_READ_CLK = 1; tick();
    in_valid = 0; IQ_RX_READ_CLK = 0;
    chk("fullpp_fill", 32'(fill_level), DEPTH);
    chk("fullpp_ovr", 32'(overrun), 0);
    tick();
    for (int k = 0; k < DEPTH; k++) pop(1);
    chk("fullpp_last", 32'(RX1_I), 32'h2FF);
    chk("fullpp_empty", 32'(in_empty), 1);

    // Single entry popped while a new one is pushed: no bubble on the head
    push(24'h0AA, 24'h0, 24'h0, 24'h0);
    tick();
    chk_head("fwd");
    sb.push_back(mk(24'h0BB, 24'h0, 24'h0, 24'h0));
    in_I = 24'h0BB; in_valid = 1; IQ_RX_READ_CLK = 1; tick();
    in_valid = 0; IQ_RX_READ_CLK = 0;
    chk("fwd_empty", 32'(in_empty), 0);
    chk("fwd_rx1i", 32'(RX1_I), 32'h0BB);
    chk("fwd_fill", 32'(fill_level), 1);
    tick();
    pop(1);

    // Second channel
    push(24'h000001, 24'h000002, 24'h7FFFFF, 24'h800000);
    tick();
    chk("dual_rx1i", 32'(RX1_I), 1);
`ifdef RX_IQ_DUAL_CHANNEL_EN
    chk("dual_rx2i", 32'(RX2_I), 32'h7FFFFF);
`else
    chk("dual_rx2i", 32'(RX2_I), 0);
`endif
    pop(1);

    // Reset mid-operation
    for (int k = 0; k < 3; k++) push(24'h300 + DW'(k), 24'h0, 24'h0, 24'h0);
    reset_n = 0; #1;
    chk("mrst_fill", 32'(fill_level), 0);
    chk("mrst_empty", 32'(in_empty), 1);
    chk("mrst_rx1i", 32'(RX1_I), 0);
    sb.delete();
    tick(); reset_n = 1; tick(); tick();
    chk("mrst_stay_empty", 32'(in_empty), 1);
    push(24'hABC, 24'h0, 24'h0, 24'h0);
    tick();
    pop(1);
    chk("mrst_drained", 32'(fill_level), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
